// File: rtl/rvx_async_fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// rvx_async_fifo_read_ctrl
//
// Read-side controller of a dual-clock FIFO.
//
// The controller takes the Gray-coded write pointer from the write clock
// domain and resynchronizes it into the read clock. From that pointer it
// derives the empty flag and the fill level. It drives the read port of the
// storage RAM, which has a one-cycle read latency. The data is presented to the
// consumer as a first-word-fall-through valid/ready stream. The controller
// returns its own registered Gray read pointer to the write side.
//
// Ports:
//   clk             read-domain clock (the only clock)
//   rstp            synchronous active-high reset
//   wptr_gray_async Gray write pointer from the write domain (asynchronous)
//   rptr_gray       registered Gray read pointer, sent to the write domain
//   mem_re          RAM read enable
//   mem_raddr       RAM read address
//   mem_rdata       RAM read data, valid one cycle after mem_re, held otherwise
//   out_valid       output word available
//   out_ready       consumer accepts the word
//   out_data        output word (RAM data passthrough)
//   empty           no entries beyond the one presented on the output
//   fill_level      entries not yet popped by the consumer, 0..2**BW_ADDR
// ----------------------------------------------------------------------------
module rvx_async_fifo_read_ctrl #(
  parameter int BW_ADDR     = 4,
  parameter int BW_PTR      = BW_ADDR + 1,
  parameter int BW_DATA     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic [BW_PTR-1:0]  wptr_gray_async,
  output logic [BW_PTR-1:0]  rptr_gray,
  output logic               mem_re,
  output logic [BW_ADDR-1:0] mem_raddr,
  input  logic [BW_DATA-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BW_DATA-1:0] out_data,
  output logic               empty,
  output logic [BW_PTR-1:0]  fill_level
);

  // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
  function automatic logic [BW_PTR-1:0] bin2gray(input logic [BW_PTR-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [BW_PTR-1:0] gray2bin(input logic [BW_PTR-1:0] gray);
    logic [BW_PTR-1:0] bin;
    bin[BW_PTR-1] = gray[BW_PTR-1];
    for (int i = BW_PTR - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  logic [BW_PTR-1:0] sync_r [SYNC_STAGES];
  logic [BW_PTR-1:0] wptr_gray_s;
  logic [BW_PTR-1:0] wptr_bin_s;
  logic [BW_PTR-1:0] rptr_bin_r;
  logic [BW_PTR-1:0] rptr_bin_nxt_s;
  logic [BW_PTR-1:0] rptr_gray_r;
  logic              out_valid_r;
  logic              empty_s;
  logic              mem_re_s;
  logic [BW_PTR-1:0] fill_level_s;

  // Write-pointer synchronizer. Only stage 0 samples the asynchronous input.
  // Because the pointer is Gray coded, a sample taken mid-transition resolves
  // to either the old value or the new value, never to anything else.
  always_ff @(posedge clk) begin
    if (rstp) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= wptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Pointer decode, empty flag, pop decision and fill level.
  always_comb begin
    wptr_gray_s    = sync_r[SYNC_STAGES-1];
    wptr_bin_s     = gray2bin(wptr_gray_s);
    rptr_bin_nxt_s = rptr_bin_r + {{(BW_PTR-1){1'b0}}, 1'b1};
    // The compare includes the wrap bit, so a full FIFO is never seen as empty.
    empty_s        = (rptr_gray_r == wptr_gray_s);
    // Fetch when data is available and the output slot is either free or
    // being vacated this cycle.
    mem_re_s       = !empty_s && (!out_valid_r || out_ready);
    // Words still in the RAM plus the word held in the output slot.
    fill_level_s   = (wptr_bin_s - rptr_bin_r) + {{(BW_PTR-1){1'b0}}, out_valid_r};
  end

  // Read pointer: advance on each RAM fetch. Gray form is registered so the
  // remote synchronizer never sees more than one bit change per step.
  always_ff @(posedge clk) begin
    if (rstp) begin
      rptr_bin_r  <= '0;
      rptr_gray_r <= '0;
    end else if (mem_re_s) begin
      rptr_bin_r  <= rptr_bin_nxt_s;
      rptr_gray_r <= bin2gray(rptr_bin_nxt_s);
    end
  end

  // Output slot occupancy. A fetch always lands in the slot one cycle later.
  // An unaccepted word stays put. The RAM output holds it because no fetch is
  // issued while the slot is full and stalled.
  always_ff @(posedge clk) begin
    if (rstp) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= mem_re_s | (out_valid_r & ~out_ready);
    end
  end

  assign rptr_gray  = rptr_gray_r;
  assign mem_re     = mem_re_s;
  assign mem_raddr  = rptr_bin_r[BW_ADDR-1:0];
  assign out_valid  = out_valid_r;
  assign out_data   = mem_rdata;
  assign empty      = empty_s;
  assign fill_level = fill_level_s;

endmodule

// File: tb/tb_rvx_async_fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for rvx_async_fifo_read_ctrl.
//
// The bench plays the write side and the RAM. The write side puts a
// recognizable word into the RAM and then advances the Gray write pointer.
// The RAM answers a read one cycle after mem_re.
//
// A count-based model predicts every output each cycle. It tracks the write
// count seen through the synchronizer delay, the absolute read count and the
// output slot. Directed literal checks pin down the key scenarios.
// ----------------------------------------------------------------------------
module tb_rvx_async_fifo_read_ctrl;

  localparam int BW_ADDR = 4;
  localparam int BW_PTR  = 5;
  localparam int BW_DATA = 32;
  localparam int SYNC    = 2;
  localparam int DEPTH   = 16;
  localparam int PMOD    = 32;

  logic               clk = 1'b0;
  logic               rstp = 1'b1;
  logic [BW_PTR-1:0]  wptr_gray_async = '0;
  logic [BW_PTR-1:0]  rptr_gray;
  logic               mem_re;
  logic [BW_ADDR-1:0] mem_raddr;
  logic [BW_DATA-1:0] mem_rdata = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [BW_DATA-1:0] out_data;
  logic               empty;
  logic [BW_PTR-1:0]  fill_level;

  int checks = 0;
  int failures = 0;

  // Write side and RAM state.
  int          w_abs = 0;
  int          gen = 0;
  logic [31:0] ram [DEPTH];

  // Model state.
  int          hist[$];
  int          m_r = 0;
  bit          m_v = 1'b0;
  logic [31:0] m_d = '0;
  bit          chk_en = 1'b0;

  // Observation logs.
  int          raddr_log[$];
  logic [31:0] pop_log[$];
  int          re_count = 0;

  rvx_async_fifo_read_ctrl #(
    .BW_ADDR(BW_ADDR), .BW_PTR(BW_PTR), .BW_DATA(BW_DATA), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rstp(rstp), .wptr_gray_async(wptr_gray_async),
    .rptr_gray(rptr_gray), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .empty(empty), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b % PMOD);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] data_of(input int k);
    return 32'hD000_0000 | (32'(gen & 255) << 16) | 32'(k & 16'hFFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM read port with one cycle of latency. The data holds while mem_re is low.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  // Model update: the synchronizer is a delay of SYNC edges, words move from
  // the RAM into the slot, and the consumer drains the slot.
  always @(posedge clk) begin
    int avail;
    bit fire;
    if (rstp) begin
      hist.delete();
      repeat (SYNC) hist.push_back(0);
      m_r = 0;
      m_v = 1'b0;
    end else begin
      avail = (hist[SYNC-1] - (m_r % PMOD) + PMOD) % PMOD;
      fire  = (avail != 0) && (!m_v || out_ready);
      if (fire) begin
        m_d = data_of(m_r);
        m_r++;
        m_v = 1'b1;
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
      hist.push_front(w_abs % PMOD);
      void'(hist.pop_back());
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int avail;
    bit e_re;
    if (chk_en) begin
      avail = (hist[SYNC-1] - (m_r % PMOD) + PMOD) % PMOD;
      e_re  = (avail != 0) && (!m_v || out_ready);
      chk("m_empty", 32'(empty), 32'(avail == 0));
      chk("m_fill", 32'(fill_level), 32'(avail + int'(m_v)));
      chk("m_mem_re", 32'(mem_re), 32'(e_re));
      if (e_re) chk("m_raddr", 32'(mem_raddr), 32'(m_r % DEPTH));
      chk("m_out_valid", 32'(out_valid), 32'(m_v));
      if (m_v) chk("m_out_data", out_data, m_d);
      chk("m_rptr_gray", 32'(rptr_gray), 32'(g(m_r)));
    end
    if (mem_re) begin
      raddr_log.push_back(int'(mem_raddr));
      re_count++;
    end
    if (out_valid && out_ready) pop_log.push_back(out_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      ram[w_abs % DEPTH] = data_of(w_abs);
      w_abs++;
    end
    wptr_gray_async = g(w_abs);
  endtask

  task automatic do_reset();
    rstp = 1'b1;
    w_abs = 0;
    gen++;
    wptr_gray_async = '0;
    @(posedge clk);
    #1;
    rstp = 1'b0;
  endtask

  initial begin
    hist.delete();
    repeat (SYNC) hist.push_back(0);
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    // Reset state.
    tick(2);
    rstp = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);

    // Single word: visible after two synchronizer edges, then out one cycle later.
    @(posedge clk);
    #1;
    write_words(1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("one_fill", 32'(fill_level), 32'd1);
    chk("one_mem_re", 32'(mem_re), 32'd1);
    chk("one_raddr", 32'(mem_raddr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("one_out_valid", 32'(out_valid), 32'd1);
    chk("one_out_data", out_data, 32'hD000_0000);
    chk("one_rptr_gray", 32'(rptr_gray), 32'd1);
    chk("one_empty", 32'(empty), 32'd1);
    chk("one_fill_held", 32'(fill_level), 32'd1);
    @(posedge clk);
    #1;
    tick(2);

    // Full FIFO with the consumer stalled.
    out_ready = 1'b0;
    do_reset();
    re_count = 0;
    write_words(16);
    tick(6);
    @(negedge clk);
    #1;
    chk("full_re_count", 32'(re_count), 32'd1);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_out_data", out_data, 32'hD001_0000);
    chk("full_fill", 32'(fill_level), 32'd16);
    chk("full_empty", 32'(empty), 32'd0);
    chk("full_mem_re", 32'(mem_re), 32'd0);

    // Release: sixteen back-to-back pops in order.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pop_log.delete();
    repeat (16) @(negedge clk);
    #1;
    chk("burst_count", 32'(pop_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < pop_log.size(); i++) begin
      chk("burst_data", pop_log[i], 32'hD001_0000 + 32'(i));
    end
    @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_fill", 32'(fill_level), 32'd0);
    chk("drain_rptr_gray", 32'(rptr_gray), 32'h18);

    // Wrap: move the read pointer to 30, then write four more words.
    @(posedge clk);
    #1;
    write_words(14);
    tick(25);
    raddr_log.delete();
    write_words(4);
    tick(12);
    @(negedge clk);
    #1;
    chk("wrap_count", 32'(raddr_log.size()), 32'd4);
    if (raddr_log.size() == 4) begin
      chk("wrap_addr0", 32'(raddr_log[0]), 32'd14);
      chk("wrap_addr1", 32'(raddr_log[1]), 32'd15);
      chk("wrap_addr2", 32'(raddr_log[2]), 32'd0);
      chk("wrap_addr3", 32'(raddr_log[3]), 32'd1);
    end
    chk("wrap_rptr_gray", 32'(rptr_gray), 32'd3);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset while a word is held and stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    write_words(1);
    tick(5);
    @(negedge clk);
    chk("prerst_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    re_count = 0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("mrst_mem_re", 32'(mem_re), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_fill", 32'(fill_level), 32'd0);
    @(posedge clk);
    #1;
    tick(5);
    chk("mrst_no_re", 32'(re_count), 32'd0);
    out_ready = 1'b1;
    write_words(2);
    tick(8);
    chk("mrst_resume_re", 32'(re_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
